top_encryption: RTL and testbench

Iterative AES-128 encryption core (FIPS-197). It takes a 128-bit plaintext block and a 128-bit cipher key on a start pulse, then computes one round per clock cycle with on-the-fly key expansion. It presents the ciphertext with a one-cycle done pulse. It is the top of the encryption datapath, intended to sit behind a host/bus wrapper that supplies blocks one at a time.

---
 rtl/aes_pkg.sv | 79 +++++++
 rtl/aes_sbox.sv | 18 +
 rtl/top_encryption.sv | 114 +++++++++++
 tb/tb_top_encryption.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// +------------------------------------------------------------------+
// | aes_pkg: shared AES-128 tables, FSM state type and round helpers |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the round number 1..10; unused slots are zero.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Byte (r,c) sits at index r+4c, counted from the MSB.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// +------------------------------------------------------------------+
// | aes_sbox: combinational AES forward S-box lookup                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] subst
);

    assign subst = SBOX[data];

endmodule

`default_nettype wire

// File: rtl/top_encryption.sv
// +------------------------------------------------------------------+
// | top_encryption: iterative AES-128 encryptor, one round per clock  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module top_encryption
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         done,
    output logic [127:0] ciphertext
);

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_next_key;
    logic [127:0] w_round_out;
    logic [31:0]  w_rot;
    logic [31:0]  w_key_sub;
    logic [31:0]  w_temp;
    logic         w_last;

    generate
        for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
            aes_sbox u_sbox (
                .data  (r_state[127-8*i -: 8]),
                .subst (w_sub[127-8*i -: 8])
            );
        end
    endgenerate

    // Key schedule word: SubWord(RotWord(w3)) ^ Rcon, then ripple across w0..w3.
    assign w_rot = {r_key[23:0], r_key[31:24]};

    generate
        for (genvar j = 0; j < 4; j++) begin : g_key_sbox
            aes_sbox u_sbox (
                .data  (w_rot[31-8*j -: 8]),
                .subst (w_key_sub[31-8*j -: 8])
            );
        end
    endgenerate

    assign w_temp                = w_key_sub ^ {RCON[r_round], 24'h0};
    assign w_next_key[127:96]    = r_key[127:96] ^ w_temp;
    assign w_next_key[95:64]     = r_key[95:64]  ^ w_next_key[127:96];
    assign w_next_key[63:32]     = r_key[63:32]  ^ w_next_key[95:64];
    assign w_next_key[31:0]      = r_key[31:0]   ^ w_next_key[63:32];

    assign w_shift     = shift_rows(w_sub);
    assign w_mix       = mix_columns(w_shift);
    assign w_last      = (r_fsm == BUSY) && (r_round == 4'd10);
    assign w_round_out = (w_last ? w_shift : w_mix) ^ w_next_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (start)  w_fsm_next = BUSY;
            BUSY:    if (w_last) w_fsm_next = IDLE;
            default: w_fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= '0;
            r_key      <= '0;
            r_round    <= 4'd0;
            ciphertext <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_fsm == IDLE) begin
                if (start) begin
                    r_state <= plaintext ^ key;
                    r_key   <= key;
                    r_round <= 4'd1;
                end
            end else begin
                r_state <= w_round_out;
                r_key   <= w_next_key;
                if (w_last) begin
                    ciphertext <= w_round_out;
                    done       <= 1'b1;
                end else begin
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_top_encryption.sv
// +------------------------------------------------------------------+
// | tb_top_encryption: randomized self-checking bench for AES-128     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_top_encryption;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         done;
    logic [127:0] ciphertext;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    logic chk_en = 1'b0;

    localparam logic [127:0] V1_KEY = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] V1_PT  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] V1_CT  = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] V2_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    top_encryption dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .done       (done),
        .ciphertext (ciphertext)
    );

    // S-box derived from first principles: GF(2^8) inverse plus affine map.
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, x[7:0]);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   st [16];
        logic [7:0]   t  [16];
        logic [31:0]  w  [44];
        logic [31:0]  tw;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = st[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Protocol model: a block captured in idle completes exactly 10 edges later.
    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_pending = '0;
    logic [127:0] m_ct = '0;
    logic         m_done = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_cnt = 0; m_ct = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1; m_cnt = 0; m_pending = aes_ref(plaintext, key);
                end
            end else begin
                m_cnt++;
                if (m_cnt == 10) begin
                    m_busy = 1'b0; m_done = 1'b1; m_ct = m_pending;
                end
            end
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (done !== m_done) begin
                errors++;
                $display("FAIL cyc_done @%0d: got %b expected %b", cyc, done, m_done);
            end
            checks++;
            if (ciphertext !== m_ct) begin
                errors++;
                $display("FAIL cyc_ct @%0d: got %h expected %h", cyc, ciphertext, m_ct);
            end
            if (done) done_count++;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_block(input logic [127:0] p, input logic [127:0] k, output int c0);
        plaintext = p; key = k; start = 1'b1;
        step();
        c0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got timeout expected done within 30 cycles");
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int c0, t1, t2, dc0;
        logic [127:0] pa, ka, pb, kb;

        build_sbox();
        check("model_v1", aes_ref(V1_PT, V1_KEY), V1_CT);
        check("model_v2", aes_ref(V2_PT, V2_KEY), V2_CT);
        check("model_sbox", {120'h0, sb[8'h53]}, {120'h0, 8'hed});

        #1 reset = 1'b0;
        chk_en = 1'b1;
        step(); step();
        check("reset_done", {127'h0, done}, 128'h0);
        check("reset_ct", ciphertext, 128'h0);

        // Vector 1
        reset = 1'b1;
        step();
        dc0 = done_count;
        start_block(V1_PT, V1_KEY, c0);
        wait_done();
        check("v1_latency", 128'(cyc - c0), 128'd10);
        check("v1_ct", ciphertext, V1_CT);
        repeat (3) step();
        check("v1_hold", ciphertext, V1_CT);
        check("v1_one_done", 128'(done_count - dc0), 128'd1);

        // Vector 2: start coincides with reset release
        reset = 1'b0;
        step();
        reset = 1'b1;
        dc0 = done_count;
        start_block(V2_PT, V2_KEY, c0);
        wait_done();
        check("v2_latency", 128'(cyc - c0), 128'd10);
        check("v2_ct", ciphertext, V2_CT);
        step(); step();
        check("v2_one_done", 128'(done_count - dc0), 128'd1);

        // Reset during round 5
        start_block(rnd128(), rnd128(), c0);
        repeat (4) step();
        dc0 = done_count;
        reset = 1'b0;
        #1;
        check("midrst_done", {127'h0, done}, 128'h0);
        check("midrst_ct", ciphertext, 128'h0);
        step(); step();
        reset = 1'b1;
        step();
        repeat (12) step();
        check("midrst_no_done", 128'(done_count - dc0), 128'd0);
        pa = rnd128(); ka = rnd128();
        start_block(pa, ka, c0);
        wait_done();
        check("midrst_latency", 128'(cyc - c0), 128'd10);
        check("midrst_ct_after", ciphertext, aes_ref(pa, ka));

        // Start pulses while busy are ignored
        step();
        dc0 = done_count;
        pa = rnd128(); ka = rnd128();
        start_block(pa, ka, c0);
        step(); step();
        plaintext = rnd128(); start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        plaintext = rnd128(); start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        check("busy_latency", 128'(cyc - c0), 128'd10);
        check("busy_ct", ciphertext, aes_ref(pa, ka));
        repeat (3) step();
        check("busy_one_done", 128'(done_count - dc0), 128'd1);

        // Back-to-back with start held high
        dc0 = done_count;
        pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
        plaintext = pa; key = ka; start = 1'b1;
        step();
        wait_done();
        t1 = cyc;
        check("b2b_ct_a", ciphertext, aes_ref(pa, ka));
        plaintext = pb; key = kb;
        step();
        start = 1'b0;
        wait_done();
        t2 = cyc;
        check("b2b_spacing", 128'(t2 - t1), 128'd11);
        check("b2b_ct_b", ciphertext, aes_ref(pb, kb));
        step();
        check("b2b_two_done", 128'(done_count - dc0), 128'd2);

        // Operands change every cycle after capture
        step();
        pa = rnd128(); ka = rnd128();
        start_block(pa, ka, c0);
        for (int i = 0; i < 30; i++) begin
            plaintext = rnd128(); key = rnd128();
            step();
            if (done) break;
        end
        check("opchg_latency", 128'(cyc - c0), 128'd10);
        check("opchg_ct", ciphertext, aes_ref(pa, ka));

        // Random blocks with random idle gaps
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 3)) step();
            pa = rnd128(); ka = rnd128();
            start_block(pa, ka, c0);
            wait_done();
            check("rand_latency", 128'(cyc - c0), 128'd10);
        end

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
